// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  localparam int FETCH_W = 32;
  localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush (priority over push/pop); head visible combinationally.
// Latency: push visible at head the cycle after; a push while full is dropped.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: single-outstanding imem requests, buffered words to decode.
// Latency: gnt cycle -> rvalid -> head valid next cycle; requests stop while the buffer is full.
module ifetch_ctrl #(
  parameter int              XLEN       = ifetch_pkg::FETCH_W,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR  = ifetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_sel,
  output logic            pc_advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            id_ready
);
  import ifetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CA_W  = CNT_W + 1;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] req_pc;
  fetch_entry_t    push_dat;
  fetch_entry_t    head_dat;
  logic            push_vld;
  logic            pop_vld;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CA_W-1:0]  count_after;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign pc_advance  = imem_req & imem_gnt & ~pc_sel;
  assign instr_valid = ~fifo_empty & ~pc_sel;
  assign pop_vld     = instr_valid & id_ready;
  assign push_vld    = (state == RESP) & imem_rvalid & ~pc_sel;
  assign push_dat    = '{pc: req_pc, instr: imem_rdata};
  assign instr       = fifo_empty ? NOP_INSTR : head_dat.instr;
  assign instr_pc    = fifo_empty ? '0 : head_dat.pc;
  assign count_after = CA_W'(fifo_count) + CA_W'(push_vld) - CA_W'(pop_vld);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_full && !pc_sel) state_nxt = REQ;
      REQ: begin
        if (imem_gnt)    state_nxt = pc_sel ? DRAIN : RESP;
        else if (pc_sel) state_nxt = IDLE;
      end
      RESP: begin
        if (imem_rvalid) begin
          if (pc_sel)                               state_nxt = IDLE;
          else if (count_after < CA_W'(FIFO_DEPTH)) state_nxt = REQ;
          else                                      state_nxt = IDLE;
        end else if (pc_sel) begin
          state_nxt = DRAIN;
        end
      end
      // The killed response still has to come back before a new request may go out.
      DRAIN: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (pc_advance) req_pc <= pc;
    end
  end

  ifetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (pc_sel),
    .push    (push_vld),
    .push_dat(push_dat),
    .pop     (pop_vld),
    .pop_dat (head_dat),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
